// File: rtl/tlb_op_ctrl_pkg.sv
// rtl/tlb_op_ctrl_pkg.sv - opcodes, TLBIDX field layout and FSM states for tlb_op_ctrl
package tlb_op_ctrl_pkg;

    localparam logic [2:0] TLBOP_SRCH = 3'd0;
    localparam logic [2:0] TLBOP_RD   = 3'd1;
    localparam logic [2:0] TLBOP_WR   = 3'd2;
    localparam logic [2:0] TLBOP_FILL = 3'd3;
    localparam logic [2:0] TLBOP_INV  = 3'd4;
    localparam logic [4:0] INVTLB_OP_MAX = 5'd6;

    // TLBIDX layout: NE at bit 31, PS at [29:24], INDEX at [15:0]
    localparam int NE_BIT    = 31;
    localparam int PS_MSB    = 29;
    localparam int PS_LSB    = 24;
    localparam int INDEX_MSB = 15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RESP,
        ST_DONE
    } state_t;

    function automatic logic [31:0] srch_wb(input logic [31:0] idx, input logic found,
                                            input logic [15:0] index);
        logic [31:0] w;
        w = idx;
        w[NE_BIT] = ~found;
        if (found) w[INDEX_MSB:0] = index;
        return w;
    endfunction

    function automatic logic [31:0] rd_wb(input logic [31:0] idx, input logic e,
                                          input logic [5:0] ps);
        logic [31:0] w;
        w = '0;
        w[INDEX_MSB:0]   = idx[INDEX_MSB:0];
        w[NE_BIT]        = ~e;
        w[PS_MSB:PS_LSB] = e ? ps : 6'd0;
        return w;
    endfunction

endpackage

// File: rtl/tlb_op_ctrl_lfsr8.sv
// rtl/tlb_op_ctrl_lfsr8.sv - 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shift left
module lfsr8 (
    input  logic       clk,
    input  logic       resetn,
    input  logic       en,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q <= seed;
        end else if (en) begin
            q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        end
    end

endmodule

// File: rtl/tlb_op_ctrl.sv
// rtl/tlb_op_ctrl.sv - sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB with CSR write-back
module tlb_op_ctrl
    import tlb_op_ctrl_pkg::*;
#(
    parameter int TLBNUM = 2,
    localparam int IW = (TLBNUM > 1) ? $clog2(TLBNUM) : 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [2:0]    op_code,
    input  logic [4:0]    inv_op,
    input  logic [9:0]    inv_asid,
    input  logic [18:0]   inv_vpn,
    input  logic [31:0]   csr_tlbehi,
    input  logic [31:0]   csr_tlbelo0,
    input  logic [31:0]   csr_tlbelo1,
    input  logic [31:0]   csr_tlbidx,
    output logic          srch_req,
    output logic [31:0]   srch_vaddr,
    input  logic          srch_found,
    input  logic [IW-1:0] srch_index,
    output logic [IW-1:0] r_index,
    input  logic [31:0]   r_tlbehi,
    input  logic [31:0]   r_tlbelo0,
    input  logic [31:0]   r_tlbelo1,
    input  logic [31:0]   r_tlbidx,
    input  logic [9:0]    r_asid,
    input  logic          r_e,
    output logic          tlbwr_en,
    output logic          tlbfill_en,
    output logic [IW-1:0] rand_index,
    output logic          invtlb_en,
    output logic [4:0]    invtlb_op,
    output logic [9:0]    invtlb_asid,
    output logic [18:0]   invtlb_vpn,
    output logic          csr_tlbidx_we,
    output logic          csr_tlbehi_we,
    output logic          csr_tlbelo0_we,
    output logic          csr_tlbelo1_we,
    output logic          csr_asid_we,
    output logic [31:0]   csr_tlbidx_wdata,
    output logic [31:0]   csr_tlbehi_wdata,
    output logic [31:0]   csr_tlbelo0_wdata,
    output logic [31:0]   csr_tlbelo1_wdata,
    output logic [9:0]    csr_asid_wdata,
    output logic          done,
    output logic          op_err
);

    state_t      state;
    logic [2:0]  op_q;
    logic        err_q;
    logic [31:0] tlbidx_q;
    logic [7:0]  lfsr_q;
    logic        accept_err;
    logic        unused_bits;

    lfsr8 u_lfsr (
        .clk    (clk),
        .resetn (resetn),
        .en     (1'b1),
        .seed   (8'h01),
        .q      (lfsr_q)
    );

    assign accept_err = (op_code > TLBOP_INV) || (op_code == TLBOP_INV && inv_op > INVTLB_OP_MAX);
    assign unused_bits = ^{csr_tlbehi[12:0], csr_tlbelo0, csr_tlbelo1, r_tlbidx[31:30],
                           r_tlbidx[23:0], lfsr_q[7:IW]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state             <= ST_IDLE;
            op_ready          <= 1'b1;
            op_q              <= '0;
            err_q             <= 1'b0;
            tlbidx_q          <= '0;
            srch_req          <= 1'b0;
            srch_vaddr        <= '0;
            r_index           <= '0;
            tlbwr_en          <= 1'b0;
            tlbfill_en        <= 1'b0;
            rand_index        <= '0;
            invtlb_en         <= 1'b0;
            invtlb_op         <= '0;
            invtlb_asid       <= '0;
            invtlb_vpn        <= '0;
            csr_tlbidx_we     <= 1'b0;
            csr_tlbehi_we     <= 1'b0;
            csr_tlbelo0_we    <= 1'b0;
            csr_tlbelo1_we    <= 1'b0;
            csr_asid_we       <= 1'b0;
            csr_tlbidx_wdata  <= '0;
            csr_tlbehi_wdata  <= '0;
            csr_tlbelo0_wdata <= '0;
            csr_tlbelo1_wdata <= '0;
            csr_asid_wdata    <= '0;
            done              <= 1'b0;
            op_err            <= 1'b0;
        end else begin
            srch_req       <= 1'b0;
            tlbwr_en       <= 1'b0;
            tlbfill_en     <= 1'b0;
            invtlb_en      <= 1'b0;
            csr_tlbidx_we  <= 1'b0;
            csr_tlbehi_we  <= 1'b0;
            csr_tlbelo0_we <= 1'b0;
            csr_tlbelo1_we <= 1'b0;
            csr_asid_we    <= 1'b0;
            done           <= 1'b0;
            op_err         <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (op_valid && op_ready) begin
                        // Strobes are launched here so they are visible during ISSUE
                        state       <= ST_ISSUE;
                        op_ready    <= 1'b0;
                        op_q        <= op_code;
                        err_q       <= accept_err;
                        tlbidx_q    <= csr_tlbidx;
                        srch_vaddr  <= {csr_tlbehi[31:13], 13'b0};
                        r_index     <= csr_tlbidx[IW-1:0];
                        rand_index  <= lfsr_q[IW-1:0];
                        invtlb_op   <= inv_op;
                        invtlb_asid <= inv_asid;
                        invtlb_vpn  <= inv_vpn;
                        srch_req    <= (op_code == TLBOP_SRCH);
                        tlbwr_en    <= (op_code == TLBOP_WR);
                        tlbfill_en  <= (op_code == TLBOP_FILL);
                        invtlb_en   <= (op_code == TLBOP_INV) && !accept_err;
                    end
                end
                ST_ISSUE: begin
                    if (!err_q && (op_q == TLBOP_SRCH || op_q == TLBOP_RD)) begin
                        state <= ST_RESP;
                    end else begin
                        state  <= ST_DONE;
                        done   <= 1'b1;
                        op_err <= err_q;
                    end
                end
                ST_RESP: begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                    if (op_q == TLBOP_SRCH) begin
                        csr_tlbidx_we    <= 1'b1;
                        csr_tlbidx_wdata <= srch_wb(tlbidx_q, srch_found, 16'(srch_index));
                    end else begin
                        csr_tlbidx_we     <= 1'b1;
                        csr_tlbehi_we     <= 1'b1;
                        csr_tlbelo0_we    <= 1'b1;
                        csr_tlbelo1_we    <= 1'b1;
                        csr_asid_we       <= 1'b1;
                        csr_tlbidx_wdata  <= rd_wb(tlbidx_q, r_e, r_tlbidx[PS_MSB:PS_LSB]);
                        csr_tlbehi_wdata  <= r_e ? r_tlbehi  : 32'd0;
                        csr_tlbelo0_wdata <= r_e ? r_tlbelo0 : 32'd0;
                        csr_tlbelo1_wdata <= r_e ? r_tlbelo1 : 32'd0;
                        csr_asid_wdata    <= r_e ? r_asid    : 10'd0;
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    op_ready <= 1'b1;
                end
                default: begin
                    state    <= ST_IDLE;
                    op_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/tlb_op_ctrl.md
# tlb_op_ctrl

Multi-cycle sequencer that executes the privileged TLB instructions TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB on behalf of the EX stage. It drives the translation unit's search, read, write and invalidate ports, samples the unit's responses, and produces CSR write-back (TLBIDX, TLBEHI, TLBELO0/1, ASID). It is the initiator and consumer side of the translation unit's maintenance interface.

## Interface
- `TLBNUM`, 2: TLB entry count; `IW = max(1, $clog2(TLBNUM))` is the index width.
- `clk`  in  1  clock
- `resetn`  in  1  reset: asynchronous and active-low
- `op_valid` / `op_ready`  in/out  1  instruction handshake from EX
- `op_code`  in  3  0=SRCH, 1=RD, 2=WR, 3=FILL, 4=INV; other values are illegal
- `inv_op`  in  5  INVTLB op field
- `inv_asid`  in  10  INVTLB ASID operand
- `inv_vpn`  in  19  INVTLB VA[31:13] operand
- `csr_tlbehi`, `csr_tlbelo0`, `csr_tlbelo1`, `csr_tlbidx`  in  32  current CSR values
- `srch_req`  out  1  steers the data search port to `srch_vaddr`
- `srch_vaddr`  out  32  `{csr_tlbehi[31:13], 13'b0}`, captured at accept
- `srch_found`  in  1  search result
- `srch_index`  in  IW  search result
- `r_index`  out  IW  read index
- `r_tlbehi`, `r_tlbelo0`, `r_tlbelo1`, `r_tlbidx`  in  32  read data
- `r_asid`  in  10  read data
- `r_e`  in  1  read data
- `tlbwr_en`, `tlbfill_en`  out  1  write strobes
- `rand_index`  out  IW  fill victim index
- `invtlb_en`  out  1  invalidate strobe
- `invtlb_op`  out  5  invalidate operand
- `invtlb_asid`  out  10  invalidate operand
- `invtlb_vpn`  out  19  invalidate operand
- `csr_tlbidx_we`, `csr_tlbehi_we`, `csr_tlbelo0_we`, `csr_tlbelo1_we`, `csr_asid_we`  out  1  CSR write strobes
- `csr_*_wdata`  out  32/32/32/32/10  CSR write data
- `done`  out  1  one-cycle completion pulse
- `op_err`  out  1  one-cycle pulse, coincident with `done`, for an illegal `op_code` or `inv_op > 6`

## Operation
- FSM states: IDLE, ISSUE, RESP, DONE.
- **IDLE**
  - `op_ready = 1`.
  - On `op_valid & op_ready`, latch the opcode, the INV operands, `srch_vaddr`, `r_index = csr_tlbidx[IW-1:0]` and `rand_index = lfsr[IW-1:0]`, then go to ISSUE.
- **ISSUE** (exactly one cycle)
  - SRCH: `srch_req = 1`, then go to RESP.
  - RD: hold `r_index`, then go to RESP.
  - WR: `tlbwr_en = 1`, then go to DONE.
  - FILL: `tlbfill_en = 1`, then go to DONE.
  - INV with legal `inv_op`: `invtlb_en = 1`, then go to DONE.
  - Illegal opcode or illegal `inv_op`: no strobe, then go to DONE with an error flagged.
- **RESP** (one cycle)
  - SRCH: register `srch_found` and `srch_index`. The search result is valid the cycle after `srch_req`.
  - RD: register all `r_*` inputs.
  - Then go to DONE.
- **DONE** (one cycle)
  - Pulse `done`, plus `op_err` if an error was flagged.
  - Assert the CSR write strobes as listed below, then go to IDLE.
- **SRCH write-back**
  - Found: `csr_tlbidx_we = 1`, wdata = `csr_tlbidx` with INDEX = index and NE = 0.
  - Not found: wdata = `csr_tlbidx` with NE = 1 and INDEX unchanged.
- **RD write-back**
  - `r_e = 1`: all five write strobes are asserted. wdata is taken from the `r_*` values; TLBIDX keeps its current INDEX with PS from `r_tlbidx` and NE = 0.
  - `r_e = 0`: all five strobes are asserted. TLBEHI, TLBELO0/1 and ASID are written with 0; TLBIDX gets NE = 1, PS = 0 and its INDEX unchanged.
- **WR, FILL, INV**: no CSR writes.
- **LFSR**
  - 8-bit, polynomial x^8+x^6+x^5+x^4+1, shift left with feedback into bit 0.
  - Reset value 8'h01; it advances every cycle in every state.
- Accepted operations are atomic. There is no flush input; the pipeline must hold until `done`.

## Timing
- With acceptance at cycle T:
  - SRCH and RD complete with `done` at T+3.
  - WR, FILL and INV complete with `done` at T+2.
  - Illegal operations complete with `done` at T+2.
- `op_ready` is 0 from T+1 until the cycle after `done`. Back-to-back operations: the next accept happens at `done`+1.
- All strobes (`srch_req`, `tlbwr_en`, `tlbfill_en`, `invtlb_en`, `csr_*_we`, `done`, `op_err`) are registered single-cycle pulses.
- Reset (asynchronous, also mid-operation):
  - state = IDLE, `op_ready = 1`.
  - All strobes and all data outputs = 0.
  - LFSR = 8'h01, and the in-flight operation is dropped.

## Structure
- Shared header `csr.h`: CSR field macros `INDEX`, `PS`, `NE`, `VPPN`.
- Shared header `tlb_op.h`: opcode localparams `TLBOP_SRCH` … `TLBOP_INV`, and `INVTLB_OP_MAX = 6`.
- One sub-module, `lfsr8` (enable, seed, `q[7:0]`); the FSM and write-back muxing stay in the top level.

## Test plan
- SRCH with `csr_tlbehi = 32'h0001_2000`, `srch_found = 1`, `srch_index = 1`, `csr_tlbidx = 32'h8C00_0000` -> `srch_vaddr = 32'h0001_2000`, `srch_req` at T+1, `csr_tlbidx_wdata = 32'h0C00_0001` with `done` at T+3.
- SRCH miss with `csr_tlbidx = 32'h0C00_0001` -> wdata = 32'h8C00_0001.
- RD with `r_e = 0` and `csr_tlbidx = 32'h0C00_0001` -> all five strobes at T+3, tlbidx wdata = 32'h8000_0001, other wdata = 0.
- RD with `r_e = 1`: TLBIDX wdata = `{0, 0, r_tlbidx[29:24], 24'b0}` with INDEX from `csr_tlbidx`; the other four wdata = `r_*` values.
- FILL immediately after reset, accepted at T = 1 with `TLBNUM = 2` -> `rand_index = 0` (LFSR = 8'h02), `tlbfill_en` at T+1, `done` at T+2. FILL accepted at T = 0 gives `rand_index = 1`.
- INV with `inv_op = 7` -> no `invtlb_en`, `op_err = done = 1` at T+2.
- `resetn` low during RESP of an RD -> no CSR strobes, `op_ready = 1` while reset is held, and a fresh SRCH afterwards completes normally.
